tile_fetch_agu: RTL
===================

Name: tile_fetch_agu

Overview:
- Sits directly downstream of the tile controller.
- Accepts one tile descriptor per tile: input-space origin, which may be negative because of padding, plus input-space height and width.
- Walks every input pixel of the tile in row-major order. For each pixel it emits a memory read address, or a pad flag when the pixel lies outside the image.
- The feature-buffer fetch unit consumes these beats, substituting zero for padded pixels.

Parameters:
- DIM_W, 16: width of dimension and index fields. Must match the tile controller.
- ADDR_W, 32: width of the emitted pixel address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- cfg_base_addr  in  ADDR_W  address of pixel (0,0). Sampled on descriptor accept.
- cfg_img_h  in  DIM_W  image height. Sampled on descriptor accept.
- cfg_img_w  in  DIM_W  image width; also the row pitch. Sampled on descriptor accept.
- desc_valid  in  1  tile descriptor valid
- desc_ready  out  1  block can accept a descriptor
- desc_in_row  in  DIM_W+1 (signed)  tile input origin row
- desc_in_col  in  DIM_W+1 (signed)  tile input origin column
- desc_in_h  in  DIM_W  tile input height
- desc_in_w  in  DIM_W  tile input width
- px_valid  out  1  pixel beat valid
- px_ready  in  1  consumer accepts beat
- px_addr  out  ADDR_W  pixel address; 0 when px_pad=1
- px_pad  out  1  pixel is outside the image
- px_r  out  DIM_W  row index local to the tile
- px_c  out  DIM_W  column index local to the tile
- px_eol  out  1  last column of the current row
- px_last  out  1  last pixel of the tile
- tile_done  out  1  one-cycle pulse after the last pixel beat
- busy  out  1  a tile is in progress

Behaviour:
- Reset values:
  - State IDLE.
  - desc_ready=1.
  - All other outputs 0, including px_valid, busy and tile_done.
  - Counters r and c = 0.
  - All latched registers = 0.
- States: IDLE, RUN.
- IDLE:
  - desc_ready=1, px_valid=0.
  - On desc_valid&&desc_ready: latch the descriptor and the cfg_* inputs; set r=c=0.
  - If desc_in_h==0 or desc_in_w==0: stay in IDLE and pulse tile_done on the next cycle. No pixel beats are emitted.
  - Otherwise go to RUN.
- RUN:
  - px_valid=1, desc_ready=0, busy=1.
  - The first beat is valid on the cycle after descriptor accept (latency 1).
  - On px_valid&&px_ready:
    - If c==w-1 and r==h-1: go to IDLE and pulse tile_done on the next cycle.
    - Else if c==w-1: c=0, r=r+1.
    - Else: c=c+1.
- No same-cycle chaining: desc_ready is low for the whole of RUN, so there is a guaranteed 1-cycle gap between tiles.
- Beat outputs are combinational from the latched registers and counters. They are stable while px_valid&&!px_ready.
- Arithmetic:
  - abs_row = in_row + r and abs_col = in_col + c, computed as signed DIM_W+2 bits.
  - px_pad = (abs_row<0) || (abs_row>=img_h) || (abs_col<0) || (abs_col>=img_w).
  - When not padded: px_addr = base + abs_row*img_w + abs_col. The multiply is unsigned 2*DIM_W bits; the sum is truncated to ADDR_W.
- px_eol = (c==w-1). px_last = px_eol && (r==h-1).
- tile_done is registered: exactly one cycle, the cycle after the final handshake. busy is 0 in that cycle.
- cfg_* inputs changing during RUN have no effect.
- desc_valid asserted during RUN is ignored until IDLE.
- Reset asserted mid-tile aborts immediately:
  - All outputs return to reset values.
  - No tile_done is generated.

Optional Feature:
- Macro: TILE_FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - perf_pad_cnt (32 bits): count of handshaked beats with px_pad=1.
  - perf_stall_cnt (32 bits): count of cycles with px_valid&&!px_ready.
- Both counters saturate at all-ones and clear only on reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Padded top-left tile: img 4x4, base 0x100, desc row=-1, col=-1, h=3, w=3, px_ready=1.
  - Exactly 9 beats.
  - Beats (0,0..2) and (1,0), (2,0) have px_pad=1, addr=0.
  - (1,1) gives addr 0x100; (1,2) gives 0x101; (2,2) gives 0x105.
  - px_eol on c=2; px_last only on beat 9; tile_done one cycle after beat 9.
- Bottom-right overhang: img 4x4, base 0x100, desc row=3, col=3, h=2, w=2.
  - Beat (0,0) gives addr 0x10F, pad=0.
  - Remaining 3 beats have pad=1.
- Backpressure: same as the first test, with px_ready low for 3 cycles at beat 5.
  - px_addr, px_pad, px_r and px_c are held constant during the stall.
  - Total of 9 beats, none duplicated or skipped.
  - With TILE_FETCH_PERF_EN: perf_stall_cnt=3, perf_pad_cnt=5.
- Zero-size descriptor: h=0, w=5.
  - No px_valid.
  - tile_done pulses the cycle after accept.
  - desc_ready stays 1.
- Back-to-back: two descriptors presented continuously.
  - Second is accepted exactly one cycle after the first tile_done cycle's preceding handshake, i.e. on the IDLE cycle.
  - Descriptors are never accepted while busy=1.
- Mid-tile reset: assert rst_n low at beat 4.
  - All outputs go to 0 (desc_ready=1) asynchronously.
  - No tile_done.
  - A new tile after reset starts at r=c=0.

Source files
------------

// File: rtl/tile_fetch_agu.sv
//============================================================================
// Module      : tile_fetch_agu
// Description : Walks a tile's input window row-major, emitting per-pixel read
//               addresses or pad flags. Optional macro TILE_FETCH_PERF_EN adds
//               saturating pad-beat and stall-cycle counters.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tile_fetch_agu #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    input  logic [DIM_W-1:0]        cfg_img_h,
    input  logic [DIM_W-1:0]        cfg_img_w,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic signed [DIM_W:0]   desc_in_row,
    input  logic signed [DIM_W:0]   desc_in_col,
    input  logic [DIM_W-1:0]        desc_in_h,
    input  logic [DIM_W-1:0]        desc_in_w,
    output logic                    px_valid,
    input  logic                    px_ready,
    output logic [ADDR_W-1:0]       px_addr,
    output logic                    px_pad,
    output logic [DIM_W-1:0]        px_r,
    output logic [DIM_W-1:0]        px_c,
    output logic                    px_eol,
    output logic                    px_last,
    output logic                    tile_done,
    output logic                    busy
`ifdef TILE_FETCH_PERF_EN
    ,
    output logic [31:0]             perf_pad_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam int C_AW    = DIM_W + 2;
    localparam int C_SUM_W = (ADDR_W > 2*DIM_W) ? ADDR_W : 2*DIM_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [DIM_W-1:0]       r_row, r_col, w_row_nxt, w_col_nxt;
    logic signed [DIM_W:0]  r_in_row, r_in_col;
    logic [DIM_W-1:0]       r_in_h, r_in_w;
    logic [ADDR_W-1:0]      r_base;
    logic [DIM_W-1:0]       r_img_h, r_img_w;
    logic                   r_tile_done, w_done_nxt;
    logic                   w_latch;
    logic                   w_run;
    logic                   w_eol, w_last_row;

    logic signed [C_AW-1:0] w_abs_row, w_abs_col;
    logic                   w_pad_raw;
    logic [2*DIM_W-1:0]     w_prod;
    logic [C_SUM_W-1:0]     w_sum;

    assign w_run      = (r_state == ST_RUN);
    assign w_eol      = (r_col == r_in_w - 1'b1);
    assign w_last_row = (r_row == r_in_h - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (desc_valid) begin
                    w_latch   = 1'b1;
                    w_row_nxt = '0;
                    w_col_nxt = '0;
                    // Empty tiles complete immediately without any beats
                    if (desc_in_h == '0 || desc_in_w == '0)
                        w_done_nxt = 1'b1;
                    else
                        w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (px_ready) begin
                    if (w_eol && w_last_row) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_eol) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + 1'b1;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_in_row    <= '0;
            r_in_col    <= '0;
            r_in_h      <= '0;
            r_in_w      <= '0;
            r_base      <= '0;
            r_img_h     <= '0;
            r_img_w     <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_tile_done <= w_done_nxt;
            if (w_latch) begin
                r_in_row <= desc_in_row;
                r_in_col <= desc_in_col;
                r_in_h   <= desc_in_h;
                r_in_w   <= desc_in_w;
                r_base   <= cfg_base_addr;
                r_img_h  <= cfg_img_h;
                r_img_w  <= cfg_img_w;
            end
        end
    end

    // Absolute coordinates carry one extra bit so origin + index never wraps
    assign w_abs_row = $signed({r_in_row[DIM_W], r_in_row}) + $signed({2'b00, r_row});
    assign w_abs_col = $signed({r_in_col[DIM_W], r_in_col}) + $signed({2'b00, r_col});

    assign w_pad_raw = w_abs_row[C_AW-1] || (w_abs_row >= $signed({2'b00, r_img_h})) ||
                       w_abs_col[C_AW-1] || (w_abs_col >= $signed({2'b00, r_img_w}));

    // Unpadded coordinates are known in-range, so the low DIM_W bits are exact
    assign w_prod = {{DIM_W{1'b0}}, w_abs_row[DIM_W-1:0]} * {{DIM_W{1'b0}}, r_img_w};
    assign w_sum  = C_SUM_W'(r_base) + C_SUM_W'(w_prod) + C_SUM_W'(w_abs_col[DIM_W-1:0]);

    // Beat fields are gated so idle/reset outputs read as zero
    assign desc_ready = ~w_run;
    assign busy       = w_run;
    assign px_valid   = w_run;
    assign px_pad     = w_run & w_pad_raw;
    assign px_addr    = (w_run && !w_pad_raw) ? w_sum[ADDR_W-1:0] : '0;
    assign px_r       = w_run ? r_row : '0;
    assign px_c       = w_run ? r_col : '0;
    assign px_eol     = w_run & w_eol;
    assign px_last    = w_run & w_eol & w_last_row;
    assign tile_done  = r_tile_done;

`ifdef TILE_FETCH_PERF_EN
    logic [31:0] r_pad_cnt, r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pad_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_run && px_ready && w_pad_raw && !(&r_pad_cnt))
                r_pad_cnt <= r_pad_cnt + 1'b1;
            if (w_run && !px_ready && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign perf_pad_cnt   = r_pad_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
